// File: rtl/fi_inject_ctrl.sv
// Fault-injection controller for a datapath under test.
//
// A free-running cycle counter drives the whole block. A fault campaign is
// loaded with a single-cycle arm pulse. When the counter reaches the loaded
// target, the loaded mask is XORed onto the datapath. The fault lasts for a
// fixed number of cycles (transient mode) or until disarm (stuck mode).
//
// Ports
//   dla_core_clk  in   single clock, rising edge
//   dla_reset     in   asynchronous active-high reset
//   arm           in   single-cycle request to load a new campaign
//   disarm        in   single-cycle abort; wins over a simultaneous arm
//   target_cycle  in   counter value that triggers injection
//   duration      in   transient length in cycles (0 is treated as 1)
//   mode          in   0 = transient, 1 = stuck until disarm
//   mask_in       in   bit-flip mask
//   data_in       in   fault-free datapath value
//   data_out      out  data_in, XORed with the loaded mask while inject_en is high
//   counter       out  free-running cycle count
//   inject_en     out  high while corruption is applied (registered)
//   busy          out  high in ARMED or INJECT (registered)
//   done          out  sticky flag, set when a transient fault completes (registered)
//
// state  | meaning
// IDLE   | no campaign loaded
// ARMED  | campaign loaded, waiting for counter == target
// INJECT | mask applied to the datapath
// DONE   | transient fault finished, done flag set
module fi_inject_ctrl #(
    parameter int CNT_W  = 32,
    parameter int DATA_W = 32
) (
    input  logic              dla_core_clk,
    input  logic              dla_reset,
    input  logic              arm,
    input  logic              disarm,
    input  logic [CNT_W-1:0]  target_cycle,
    input  logic [7:0]        duration,
    input  logic              mode,
    input  logic [DATA_W-1:0] mask_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  counter,
    output logic              inject_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_INJECT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [7:0]        len_q, len_d;
    logic              mode_q, mode_d;
    logic              inject_d, busy_d, done_d;

    always_ff @(posedge dla_core_clk or posedge dla_reset) begin
        if (dla_reset) begin
            counter   <= '0;
            state_q   <= ST_IDLE;
            target_q  <= '0;
            mask_q    <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            inject_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            counter   <= counter + CNT_W'(1);
            state_q   <= state_d;
            target_q  <= target_d;
            mask_q    <= mask_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            inject_en <= inject_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        mask_d   = mask_q;
        len_d    = len_q;
        mode_d   = mode_q;
        done_d   = done;

        if (disarm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        target_d = target_cycle;
                        mask_d   = mask_in;
                        mode_d   = mode;
                        len_d    = (duration == 8'd0) ? 8'd1 : duration;
                        done_d   = 1'b0;
                        state_d  = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Compared only from the cycle after arm, so a target equal
                    // to or behind the current count fires after the wrap.
                    if (counter == target_q) begin
                        state_d = ST_INJECT;
                    end
                end
                ST_INJECT: begin
                    len_d = len_q - 8'd1;
                    if (!mode_q && (len_q == 8'd1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Registered outputs follow the next state, so they change on the
        // same edge as the FSM.
        inject_d = (state_d == ST_INJECT);
        busy_d   = (state_d == ST_ARMED) || (state_d == ST_INJECT);
    end

    assign data_out = inject_en ? (data_in ^ mask_q) : data_in;

endmodule

// File: tb/tb_fi_inject_ctrl.sv
module tb_fi_inject_ctrl;

    logic        clk;
    logic        rst;

    logic        arm, disarm, mode;
    logic [31:0] target_cycle, mask_in, data_in, data_out, counter;
    logic [7:0]  duration;
    logic        inject_en, busy, done;

    logic        arm4, disarm4, mode4;
    logic [3:0]  target4, counter4;
    logic [7:0]  duration4, mask4, data_in4, data_out4;
    logic        inject4, busy4, done4;

    int          n_checks;
    int          n_fail;

    logic        exp_inj, exp_busy, exp_done;
    logic [31:0] exp_data;
    logic [7:0]  exp_data4;

    fi_inject_ctrl #(.CNT_W(32), .DATA_W(32)) dut (
        .dla_core_clk (clk),
        .dla_reset    (rst),
        .arm          (arm),
        .disarm       (disarm),
        .target_cycle (target_cycle),
        .duration     (duration),
        .mode         (mode),
        .mask_in      (mask_in),
        .data_in      (data_in),
        .data_out     (data_out),
        .counter      (counter),
        .inject_en    (inject_en),
        .busy         (busy),
        .done         (done)
    );

    fi_inject_ctrl #(.CNT_W(4), .DATA_W(8)) dut4 (
        .dla_core_clk (clk),
        .dla_reset    (rst),
        .arm          (arm4),
        .disarm       (disarm4),
        .target_cycle (target4),
        .duration     (duration4),
        .mode         (mode4),
        .mask_in      (mask4),
        .data_in      (data_in4),
        .data_out     (data_out4),
        .counter      (counter4),
        .inject_en    (inject4),
        .busy         (busy4),
        .done         (done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(negedge clk);
    endtask

    // Leaves the bench on a falling edge with both counters at 0.
    task automatic do_reset;
        arm = 0; disarm = 0; mode = 0; target_cycle = 0; duration = 0;
        mask_in = 0; data_in = 0;
        arm4 = 0; disarm4 = 0; mode4 = 0; target4 = 0; duration4 = 0;
        mask4 = 0; data_in4 = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        data_in = 32'h1234_5678;
        #1;
        n_checks++;
        if (counter !== 32'd0 || inject_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_state: counter=%0d inject_en=%b busy=%b done=%b, want 0 0 0 0",
                     counter, inject_en, busy, done);
            n_fail++;
        end
        n_checks++;
        if (data_out !== 32'h1234_5678) begin
            $display("FAIL reset_data: data_out=%h want 12345678", data_out);
            n_fail++;
        end
        tick();
        n_checks++;
        if (counter !== 32'd1 || counter4 !== 4'd1) begin
            $display("FAIL reset_first_edge: counter=%0d counter4=%0d want 1 1", counter, counter4);
            n_fail++;
        end
    endtask

    task automatic test_transient;
        do_reset();
        data_in = 32'hA5; target_cycle = 10; duration = 3; mode = 0; mask_in = 32'h1;
        arm = 1;
        tick();
        arm = 0;
        for (int c = 1; c <= 16; c++) begin
            exp_inj  = (c >= 11 && c <= 13);
            exp_busy = (c <= 13);
            exp_done = (c >= 14);
            exp_data = exp_inj ? 32'hA4 : 32'hA5;
            n_checks++;
            if (counter !== 32'(c) || inject_en !== exp_inj || busy !== exp_busy ||
                done !== exp_done || data_out !== exp_data) begin
                $display("FAIL transient c=%0d: counter=%0d inj=%b busy=%b done=%b data=%h, want %0d %b %b %b %h",
                         c, counter, inject_en, busy, done, data_out, c, exp_inj, exp_busy, exp_done, exp_data);
                n_fail++;
            end
            tick();
        end
        disarm = 1;
        tick();
        disarm = 0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL disarm_keeps_done: done=%b busy=%b want 1 0", done, busy);
            n_fail++;
        end
        target_cycle = 100; arm = 1;
        tick();
        arm = 0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL rearm_clears_done: done=%b busy=%b want 0 1", done, busy);
            n_fail++;
        end
    endtask

    task automatic test_duration_zero;
        do_reset();
        data_in = 32'hFFFF_0000; target_cycle = 4; duration = 0; mode = 0; mask_in = 32'h0000_FFFF;
        arm = 1;
        tick();
        arm = 0;
        for (int c = 1; c <= 8; c++) begin
            exp_inj  = (c == 5);
            exp_done = (c >= 6);
            exp_data = exp_inj ? 32'hFFFF_FFFF : 32'hFFFF_0000;
            n_checks++;
            if (inject_en !== exp_inj || done !== exp_done || data_out !== exp_data) begin
                $display("FAIL dur0 c=%0d: inj=%b done=%b data=%h, want %b %b %h",
                         c, inject_en, done, data_out, exp_inj, exp_done, exp_data);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_stuck;
        do_reset();
        data_in = 32'h0F; target_cycle = 5; duration = 2; mode = 1; mask_in = 32'hF0;
        arm = 1;
        tick();
        arm = 0;
        for (int c = 1; c <= 24; c++) begin
            exp_inj  = (c >= 6 && c <= 20);
            exp_busy = (c <= 20);
            exp_data = exp_inj ? 32'hFF : 32'h0F;
            n_checks++;
            if (inject_en !== exp_inj || busy !== exp_busy || done !== 1'b0 || data_out !== exp_data) begin
                $display("FAIL stuck c=%0d: inj=%b busy=%b done=%b data=%h, want %b %b 0 %h",
                         c, inject_en, busy, done, data_out, exp_inj, exp_busy, exp_data);
                n_fail++;
            end
            disarm = (c == 20);
            tick();
        end
        disarm = 0;
    endtask

    task automatic test_wrap;
        do_reset();
        for (int k = 0; k < 12; k++) tick();
        data_in4 = 8'h3C; target4 = 4'd3; duration4 = 2; mode4 = 0; mask4 = 8'h81;
        arm4 = 1;
        tick();
        arm4 = 0;
        for (int k = 13; k <= 24; k++) begin
            exp_inj   = (k == 20 || k == 21);
            exp_busy  = (k <= 21);
            exp_done  = (k >= 22);
            exp_data4 = exp_inj ? 8'hBD : 8'h3C;
            n_checks++;
            if (counter4 !== 4'(k % 16) || inject4 !== exp_inj || busy4 !== exp_busy ||
                done4 !== exp_done || data_out4 !== exp_data4) begin
                $display("FAIL wrap k=%0d: counter4=%0d inj=%b busy=%b done=%b data=%h, want %0d %b %b %b %h",
                         k, counter4, inject4, busy4, done4, data_out4, k % 16, exp_inj, exp_busy, exp_done, exp_data4);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_arm_disarm;
        do_reset();
        data_in = 32'h55; target_cycle = 2; duration = 1; mode = 0; mask_in = 32'h3;
        arm = 1; disarm = 1;
        tick();
        arm = 0; disarm = 0;
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if (busy !== 1'b0 || inject_en !== 1'b0 || data_out !== 32'h55) begin
                $display("FAIL arm_disarm_same c=%0d: busy=%b inj=%b data=%h want 0 0 55",
                         c, busy, inject_en, data_out);
                n_fail++;
            end
            if (c < 3) tick();
        end
        // c = 3: load a campaign, then try to overwrite it while ARMED.
        target_cycle = 8; duration = 2; mask_in = 32'h01;
        arm = 1;
        tick();
        target_cycle = 5; duration = 7; mask_in = 32'h80;
        tick();
        arm = 0;
        for (int c = 5; c <= 12; c++) begin
            exp_inj  = (c == 9 || c == 10);
            exp_done = (c >= 11);
            exp_data = exp_inj ? 32'h54 : 32'h55;
            n_checks++;
            if (inject_en !== exp_inj || done !== exp_done || data_out !== exp_data) begin
                $display("FAIL arm_ignored c=%0d: inj=%b done=%b data=%h, want %b %b %h",
                         c, inject_en, done, data_out, exp_inj, exp_done, exp_data);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_mid_inject_reset;
        do_reset();
        data_in = 32'h0F; target_cycle = 3; duration = 10; mode = 0; mask_in = 32'hFF;
        arm = 1;
        tick();
        arm = 0;
        for (int c = 1; c < 5; c++) tick();
        n_checks++;
        if (inject_en !== 1'b1 || data_out !== 32'hF0) begin
            $display("FAIL pre_reset_inject: inj=%b data=%h want 1 f0", inject_en, data_out);
            n_fail++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (inject_en !== 1'b0 || data_out !== 32'h0F || counter !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL async_reset: inj=%b data=%h counter=%0d busy=%b done=%b want 0 0f 0 0 0",
                     inject_en, data_out, counter, busy, done);
            n_fail++;
        end
        #1 rst = 1'b0;
        tick();
        n_checks++;
        if (counter !== 32'd1 || inject_en !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL post_reset: counter=%0d inj=%b busy=%b want 1 0 0", counter, inject_en, busy);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        test_reset();
        test_transient();
        test_duration_zero();
        test_stuck();
        test_wrap();
        test_arm_disarm();
        test_mid_inject_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
